// File: rtl/mxn_result_serializer.sv
// mxn_result_serializer: takes one packed result word of SETS x WIDTH bits
// and emits it one set per beat, low set first, over a valid/ready stream.

// Per-set select lane: passes its set through only when the frame index
// points at it, so the top can OR all lanes into the output mux.
module mxn_set_lane #(
  parameter int WIDTH = 4,
  parameter int IDXW  = 1,
  parameter int LANE  = 0
) (
  input  logic [WIDTH-1:0] set_data,
  input  logic [IDXW-1:0]  idx,
  output logic [WIDTH-1:0] lane_out
);
  assign lane_out = (idx == IDXW'(LANE)) ? set_data : '0;
endmodule

module mxn_result_serializer #(
  parameter int WIDTH = 4,
  parameter int SETS  = 2,
  parameter int IDXW  = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SETS*WIDTH-1:0]   in_packed,
  input  logic [2:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [IDXW-1:0]         out_idx,
  output logic                    out_last,
  output logic [2:0]              out_op,
  output logic [7:0]              frame_cnt
);

  if (SETS < 1 || SETS > 256) begin : g_bad_sets
    $error("mxn_result_serializer: SETS must be in 1..256");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t                      state_q, state_d;
  logic [IDXW-1:0]             idx_q, idx_d;
  logic [SETS-1:0][WIDTH-1:0]  frame_q, frame_d;
  logic [2:0]                  op_q, op_d;
  logic [7:0]                  cnt_q, cnt_d;

  logic [SETS-1:0][WIDTH-1:0]  lane_out;
  logic [WIDTH-1:0]            sel_data;
  logic                        sending, is_last, accept, beat;

  assign sending = (state_q == SEND);
  assign is_last = sending && (idx_q == IDXW'(SETS - 1));
  // Accept in IDLE, or on the final beat so frames can run back-to-back.
  // Held low during reset so nothing is taken while the block is cleared.
  assign in_ready = rst_n && (!sending || (is_last && out_ready));
  assign accept   = in_valid && in_ready;
  assign beat     = sending && out_ready;

  for (genvar g = 0; g < SETS; g++) begin : g_lane
    mxn_set_lane #(.WIDTH(WIDTH), .IDXW(IDXW), .LANE(g)) u_lane (
      .set_data (frame_q[g]),
      .idx      (idx_q),
      .lane_out (lane_out[g])
    );
  end

  // Collapse the one-hot lane outputs into the selected set.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < SETS; i++) sel_data |= lane_out[i];
  end

  // Outputs are forced to zero outside SEND so IDLE looks clean downstream.
  assign out_valid = sending;
  assign out_data  = sending ? sel_data : '0;
  assign out_idx   = sending ? idx_q : '0;
  assign out_last  = is_last;
  assign out_op    = sending ? op_q : 3'd0;
  assign frame_cnt = cnt_q;

  // Next-state: walk sets 0..SETS-1, reload on a last beat if a word waits.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          idx_d   = '0;
          frame_d = in_packed;
          op_d    = in_op;
        end
      end
      SEND: begin
        if (beat) begin
          if (!is_last) begin
            idx_d = idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
            idx_d = '0;
            if (accept) begin
              frame_d = in_packed;
              op_d    = in_op;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      op_q    <= 3'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mxn_result_serializer.sv
// Bench for mxn_result_serializer: directed vector table, reset and SETS=1
// sequences, then random traffic against a queue-based beat model.
module tb_mxn_result_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance: WIDTH=4, SETS=2
  logic       iv, ordy, ir, ov, oi, ol;
  logic [7:0] pk, fc;
  logic [2:0] op, oo;
  logic [3:0] od;

  // SETS=1, WIDTH=8 instance
  logic       iv1, ordy1, ir1, ov1, ol1;
  logic [0:0] oi1;
  logic [7:0] pk1, od1, fc1;
  logic [2:0] op1, oo1;

  int nvec = 0;
  int nmis = 0;

  mxn_result_serializer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_packed(pk),
    .in_op(op), .out_valid(ov), .out_ready(ordy), .out_data(od), .out_idx(oi),
    .out_last(ol), .out_op(oo), .frame_cnt(fc)
  );

  mxn_result_serializer #(.WIDTH(8), .SETS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_packed(pk1),
    .in_op(op1), .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_idx(oi1),
    .out_last(ol1), .out_op(oo1), .frame_cnt(fc1)
  );

  typedef struct {
    logic       iv;
    logic [7:0] pk;
    logic [2:0] op;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic [3:0] d;
    logic       idx;
    logic       last;
    logic [2:0] eop;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[20];

  // Queue model: remaining beats of the frame in flight
  typedef struct { logic [3:0] d; logic idx; logic last; logic [2:0] op; } beat_t;
  beat_t      mq[$];
  logic [7:0] mcnt;

  task automatic chk(input string nm, input logic eir, input logic eov,
                     input logic [3:0] ed, input logic eidx, input logic elast,
                     input logic [2:0] eop, input logic [7:0] ecnt);
    nvec++;
    if ({ir, ov, od, oi, ol, oo, fc} !== {eir, eov, ed, eidx, elast, eop, ecnt}) begin
      nmis++;
      $display("FAIL %s: got ir=%b ov=%b d=%h idx=%b last=%b op=%0d cnt=%0d, want ir=%b ov=%b d=%h idx=%b last=%b op=%0d cnt=%0d",
               nm, ir, ov, od, oi, ol, oo, fc, eir, eov, ed, eidx, elast, eop, ecnt);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] p, input logic [2:0] o, input logic r);
    iv = v; pk = p; op = o; ordy = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    iv1 = 1'b0; pk1 = 8'h00; op1 = 3'd0; ordy1 = 1'b0;
    @(negedge clk); #1;
    chk("reset_state", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 8'd0);
    nvec++;
    if ({ir1, ov1, ol1, fc1} !== 11'd0) begin
      nmis++;
      $display("FAIL reset_state_s1: got ir=%b ov=%b last=%b cnt=%0d, want all 0", ir1, ov1, ol1, fc1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    iv1 = 1'b0; pk1 = 8'h00; op1 = 3'd0; ordy1 = 1'b0;

    //          iv  pk     op  rdy  ir  ov  d     idx last eop cnt
    tbl[0]  = '{1, 8'hA5, 5, 1,   1,  0,  4'h0, 0,  0,   0,  0};
    tbl[1]  = '{0, 8'h00, 0, 1,   0,  1,  4'h5, 0,  0,   5,  0};
    tbl[2]  = '{0, 8'h00, 0, 1,   1,  1,  4'hA, 1,  1,   5,  0};
    tbl[3]  = '{0, 8'h00, 0, 1,   1,  0,  4'h0, 0,  0,   0,  1};
    tbl[4]  = '{1, 8'h3C, 2, 1,   1,  0,  4'h0, 0,  0,   0,  1};
    tbl[5]  = '{0, 8'h00, 0, 0,   0,  1,  4'hC, 0,  0,   2,  1};
    tbl[6]  = '{0, 8'h00, 0, 0,   0,  1,  4'hC, 0,  0,   2,  1};
    tbl[7]  = '{0, 8'h00, 0, 0,   0,  1,  4'hC, 0,  0,   2,  1};
    tbl[8]  = '{0, 8'h00, 0, 1,   0,  1,  4'hC, 0,  0,   2,  1};
    tbl[9]  = '{0, 8'h00, 0, 1,   1,  1,  4'h3, 1,  1,   2,  1};
    tbl[10] = '{1, 8'h12, 1, 1,   1,  0,  4'h0, 0,  0,   0,  2};
    tbl[11] = '{1, 8'h34, 3, 1,   0,  1,  4'h2, 0,  0,   1,  2};
    tbl[12] = '{1, 8'h34, 3, 1,   1,  1,  4'h1, 1,  1,   1,  2};
    tbl[13] = '{0, 8'h00, 0, 1,   0,  1,  4'h4, 0,  0,   3,  3};
    tbl[14] = '{0, 8'h00, 0, 1,   1,  1,  4'h3, 1,  1,   3,  3};
    tbl[15] = '{0, 8'h00, 0, 0,   1,  0,  4'h0, 0,  0,   0,  4};
    tbl[16] = '{1, 8'h96, 7, 1,   1,  0,  4'h0, 0,  0,   0,  4};
    tbl[17] = '{0, 8'h00, 0, 1,   0,  1,  4'h6, 0,  0,   7,  4};
    tbl[18] = '{0, 8'h00, 0, 1,   1,  1,  4'h9, 1,  1,   7,  4};
    tbl[19] = '{0, 8'h00, 0, 1,   1,  0,  4'h0, 0,  0,   0,  5};

    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tbl[i].iv, tbl[i].pk, tbl[i].op, tbl[i].ordy);
      #1;
      chk($sformatf("vec%0d", i), tbl[i].ir, tbl[i].ov, tbl[i].d, tbl[i].idx,
          tbl[i].last, tbl[i].eop, tbl[i].cnt);
    end

    // Reset mid-frame: set 0 of F0 goes out, then reset drops set 1
    @(negedge clk); drive(1'b1, 8'hF0, 3'd4, 1'b1);
    @(negedge clk); drive(1'b0, 8'h00, 3'd0, 1'b1); #1;
    chk("midrst_set0", 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 3'd4, 8'd5);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("midrst_asserted", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 8'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("midrst_after", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 8'd0);
    end
    // Release coincides with a word on offer: taken on the first edge
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; drive(1'b1, 8'h7E, 3'd6, 1'b1);
    @(negedge clk); drive(1'b0, 8'h00, 3'd0, 1'b0); #1;
    chk("first_edge_accept", 1'b0, 1'b1, 4'hE, 1'b0, 1'b0, 3'd6, 8'd0);

    // SETS=1: 300 frames back-to-back, one beat per cycle
    do_reset();
    for (int k = 0; k <= 301; k++) begin
      @(negedge clk);
      iv1 = (k < 300); pk1 = 8'(k); op1 = 3'(k % 7); ordy1 = 1'b1;
      #1;
      nvec++;
      if (k == 0 || k == 301) begin
        if (ov1 !== 1'b0 || fc1 !== (k == 0 ? 8'd0 : 8'd44) || ir1 !== 1'b1) begin
          nmis++;
          $display("FAIL s1_edge k=%0d: got ov=%b ir=%b cnt=%0d, want ov=0 ir=1 cnt=%0d",
                   k, ov1, ir1, fc1, (k == 0 ? 0 : 44));
        end
      end else if ({ov1, ol1, ir1, oi1, od1, oo1, fc1} !==
                   {1'b1, 1'b1, 1'b1, 1'b0, 8'(k - 1), 3'((k - 1) % 7), 8'(k - 1)}) begin
        nmis++;
        $display("FAIL s1_stream k=%0d: got ov=%b last=%b ir=%b d=%h op=%0d cnt=%0d, want 1 1 1 d=%h op=%0d cnt=%0d",
                 k, ov1, ol1, ir1, od1, oo1, fc1, 8'(k - 1), (k - 1) % 7, 8'(k - 1));
      end
    end
    iv1 = 1'b0; ordy1 = 1'b0;

    // Random traffic against the queue model
    do_reset();
    mq.delete();
    mcnt = 8'd0;
    for (int n = 0; n < 600; n++) begin
      logic       eir, acc;
      logic [7:0] w;
      logic [2:0] o;
      beat_t      h;
      @(negedge clk);
      w = 8'($urandom);
      o = 3'($urandom_range(0, 7));
      drive(($urandom_range(0, 3) != 0), w, o, ($urandom_range(0, 9) < 7));
      #1;
      eir = (mq.size() == 0) || (mq.size() == 1 && ordy);
      if (mq.size() == 0) h = '{4'h0, 1'b0, 1'b0, 3'd0};
      else                h = mq[0];
      chk("random", eir, (mq.size() != 0), h.d, h.idx, h.last, h.op, mcnt);
      acc = iv && eir;
      if (mq.size() != 0 && ordy) begin
        if (mq[0].last) mcnt = mcnt + 8'd1;
        void'(mq.pop_front());
      end
      if (acc) begin
        mq.push_back('{w[3:0], 1'b0, 1'b0, o});
        mq.push_back('{w[7:4], 1'b1, 1'b1, o});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
